// File: rtl/hack_fetch_ctrl_if.sv
// Signal bundle between the Hack fetch controller and its environment:
// run control, hPC, instruction ROM and execute stage.
interface hack_fetch_ctrl_if;
    logic        run;
    logic [15:0] pc_in;
    logic        pc_reset;
    logic        pc_load;
    logic        pc_inc;
    logic [15:0] pc_target;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] a_reg;
    logic        zr;
    logic        ng;
    logic        exec_done;
    logic [15:0] instr;
    logic        instr_valid;
    logic        rom_err;

    modport master (
        input  run, pc_in, rom_ack, rom_data, a_reg, zr, ng, exec_done,
        output pc_reset, pc_load, pc_inc, pc_target, rom_req, rom_addr,
               instr, instr_valid, rom_err
    );

    modport slave (
        output run, pc_in, rom_ack, rom_data, a_reg, zr, ng, exec_done,
        input  pc_reset, pc_load, pc_inc, pc_target, rom_req, rom_addr,
               instr, instr_valid, rom_err
    );
endinterface

// File: rtl/hack_fetch_ctrl.sv
// Hack CPU fetch/execute sequencer: resets the PC, fetches from ROM with a
// 16-cycle timeout, waits for execute, then loads or increments the PC.
module hack_fetch_ctrl (
    input logic               clock,
    input logic               reset,
    hack_fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {StPcRst, StIdle, StFetch, StExec, StUpdate} state_e;

    state_e      state_q, state_d;
    logic [3:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [15:0] instr_q, instr_d;
    logic        jump_q, jump_d;
    logic [15:0] target_q, target_d;
    logic        jump_now;

    assign jump_now = instr_q[15] & ((instr_q[2] & bus.ng) | (instr_q[1] & bus.zr) |
                                     (instr_q[0] & ~bus.ng & ~bus.zr));

    assign bus.instr   = instr_q;
    assign bus.rom_err = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StPcRst;
            tmo_q    <= 4'd0;
            err_q    <= 1'b0;
            instr_q  <= 16'd0;
            jump_q   <= 1'b0;
            target_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            instr_q  <= instr_d;
            jump_q   <= jump_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        tmo_d           = tmo_q;
        err_d           = err_q;
        instr_d         = instr_q;
        jump_d          = jump_q;
        target_d        = target_q;
        bus.pc_reset    = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.pc_target   = 16'd0;
        bus.rom_req     = 1'b0;
        bus.rom_addr    = 16'd0;
        bus.instr_valid = 1'b0;

        case (state_q)
            StPcRst: begin
                // Held in StPcRst during reset; the pulse must only appear after release.
                bus.pc_reset = ~reset;
                state_d      = StIdle;
            end
            StIdle: begin
                if (bus.run && !err_q) begin
                    state_d = StFetch;
                    tmo_d   = 4'd0;
                end
            end
            StFetch: begin
                bus.rom_req  = 1'b1;
                bus.rom_addr = bus.pc_in;
                if (bus.rom_ack) begin
                    instr_d = bus.rom_data;
                    state_d = StExec;
                end else if (tmo_q == 4'hF) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            StExec: begin
                bus.instr_valid = 1'b1;
                if (bus.exec_done) begin
                    jump_d   = jump_now;
                    target_d = bus.a_reg;
                    state_d  = StUpdate;
                end
            end
            StUpdate: begin
                bus.pc_load   = jump_q;
                bus.pc_inc    = ~jump_q;
                bus.pc_target = jump_q ? target_q : 16'd0;
                if (bus.run) begin
                    state_d = StFetch;
                    tmo_d   = 4'd0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StPcRst;
        endcase
    end

endmodule

// File: tb/tb_hack_fetch_ctrl.sv
// Scoreboard bench for hack_fetch_ctrl: a driver issues fetch/execute traffic and
// queues expectations from an ALU-result-level jump model; a monitor compares.
module tb_hack_fetch_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;

    hack_fetch_ctrl_if bus ();

    hack_fetch_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Environment hPC; starts at a non-zero value so the reset pulse matters.
    logic [15:0] hpc = 16'h1234;
    always @(posedge clock) begin
        if (bus.pc_reset)     hpc <= 16'd0;
        else if (bus.pc_load) hpc <= bus.pc_target;
        else if (bus.pc_inc)  hpc <= hpc + 16'd1;
    end
    assign bus.pc_in = hpc;

    logic [15:0] fetch_q[$];
    logic [15:0] instr_exp_q[$];
    logic [16:0] upd_q[$];
    logic [15:0] ref_pc;

    // Monitor
    logic [15:0] cur_instr = 16'd0;
    logic        prev_valid = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.rom_req && bus.rom_ack) begin
                if (fetch_q.size() == 0) check("unexpected_fetch", 1, 0);
                else check("rom_addr", {16'd0, bus.rom_addr}, {16'd0, fetch_q.pop_front()});
            end
            if (bus.instr_valid && !prev_valid) begin
                if (instr_exp_q.size() == 0) check("unexpected_exec", 1, 0);
                else cur_instr = instr_exp_q.pop_front();
            end
            if (bus.instr_valid) check("instr", {16'd0, bus.instr}, {16'd0, cur_instr});
            if (bus.exec_done) check("exec_done_in_exec", {31'd0, bus.instr_valid}, 1);
            if (bus.pc_load || bus.pc_inc) begin
                if (upd_q.size() == 0) begin
                    check("unexpected_pc_pulse", 1, 0);
                end else begin
                    logic [16:0] e;
                    e = upd_q.pop_front();
                    check("pc_load", {31'd0, bus.pc_load}, {31'd0, e[16]});
                    check("pc_inc", {31'd0, bus.pc_inc}, {31'd0, !e[16]});
                    check("pc_target", {16'd0, bus.pc_target}, e[16] ? {16'd0, e[15:0]} : 32'd0);
                end
            end
            if (!bus.pc_load) check("pc_target_zero", {16'd0, bus.pc_target}, 0);
            check("pc_exclusive",
                  {31'd0, (32'(bus.pc_reset) + 32'(bus.pc_load) + 32'(bus.pc_inc)) <= 32'd1}, 1);
            prev_valid = bus.instr_valid;
        end
    end

    // One instruction: fetch latency, execute delay, ALU result value, A value.
    task automatic do_instr(input logic [15:0] data, input int lat, input int edly,
                            input logic signed [15:0] v, input logic [15:0] a,
                            input bit run_after);
        int  n;
        bit  jump;
        n = 0;
        @(posedge clock); #1;
        while (!bus.rom_req && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        if (!bus.rom_req) begin
            check("fetch_wait", 0, 1);
            return;
        end
        repeat (lat) begin
            @(posedge clock); #1;
        end
        bus.rom_ack  = 1'b1;
        bus.rom_data = data;
        fetch_q.push_back(ref_pc);
        instr_exp_q.push_back(data);
        @(posedge clock); #1;
        bus.rom_ack  = 1'b0;
        bus.rom_data = 16'($urandom);
        repeat (edly) begin
            bus.rom_ack  = 1'($urandom_range(0, 1));
            bus.rom_data = 16'($urandom);
            @(posedge clock); #1;
        end
        bus.rom_ack   = 1'b0;
        bus.zr        = (v == 16'sd0);
        bus.ng        = (v < 16'sd0);
        bus.a_reg     = a;
        bus.exec_done = 1'b1;
        jump = data[15] && ((v < 0 && data[2]) || (v == 0 && data[1]) || (v > 0 && data[0]));
        upd_q.push_back({jump, a});
        ref_pc = jump ? a : ref_pc + 16'd1;
        if (!run_after) bus.run = 1'b0;
        @(posedge clock); #1;
        bus.exec_done = 1'b0;
        bus.zr        = 1'($urandom_range(0, 1));
        bus.ng        = 1'($urandom_range(0, 1));
        if (!run_after) begin
            @(posedge clock); #1;
            check("idle_no_req_0", {31'd0, bus.rom_req}, 0);
            @(posedge clock); #1;
            check("idle_no_req_1", {31'd0, bus.rom_req}, 0);
            bus.run = 1'b1;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_pc_reset"}, {31'd0, bus.pc_reset}, 0);
        check({tag, "_pc_load"}, {31'd0, bus.pc_load}, 0);
        check({tag, "_pc_inc"}, {31'd0, bus.pc_inc}, 0);
        check({tag, "_pc_target"}, {16'd0, bus.pc_target}, 0);
        check({tag, "_rom_req"}, {31'd0, bus.rom_req}, 0);
        check({tag, "_rom_addr"}, {16'd0, bus.rom_addr}, 0);
        check({tag, "_instr"}, {16'd0, bus.instr}, 0);
        check({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 0);
        check({tag, "_rom_err"}, {31'd0, bus.rom_err}, 0);
    endtask

    initial begin
        int cnt;
        logic signed [15:0] v;
        bus.run       = 1'b0;
        bus.rom_ack   = 1'b0;
        bus.rom_data  = 16'd0;
        bus.a_reg     = 16'd0;
        bus.zr        = 1'b0;
        bus.ng        = 1'b0;
        bus.exec_done = 1'b0;
        ref_pc        = 16'd0;

        // Power-on reset, then release with run low.
        #2 check_cleared("rst");
        @(posedge clock); #1;
        reset = 1'b0;
        #3 check("pc_reset_pulse", {31'd0, bus.pc_reset}, 1);
        @(posedge clock); #1;
        check("pc_reset_single", {31'd0, bus.pc_reset}, 0);
        repeat (3) begin
            @(posedge clock); #1;
            check("park_idle", {31'd0, bus.rom_req}, 0);
        end
        check("hpc_after_reset", {16'd0, hpc}, 0);

        // Directed programs.
        bus.run = 1'b1;
        do_instr(16'hE307, 1, 0, 16'sd1, 16'h0005, 1'b1);
        do_instr(16'h0010, 3, 1, 16'sd0, 16'h0000, 1'b1);
        do_instr(16'hE302, 0, 2, 16'sd0, 16'h0042, 1'b1);
        do_instr(16'hE302, 2, 0, 16'sd7, 16'h0042, 1'b1);
        do_instr(16'hE307, 1, 1, -16'sd3, 16'h0100, 1'b1);
        do_instr(16'h0007, 0, 0, 16'sd0, 16'h0200, 1'b0);
        do_instr(16'hE307, 0, 0, 16'sd9, 16'hFFFF, 1'b1);
        do_instr(16'h1234, 1, 0, 16'sd0, 16'h0000, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 2))
                0:       v = 16'sd0;
                1:       v = -$signed(16'($urandom_range(1, 1000)));
                default: v = $signed(16'($urandom_range(1, 1000)));
            endcase
            do_instr(16'($urandom), $urandom_range(0, 5), $urandom_range(0, 4), v,
                     ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom),
                     $urandom_range(0, 4) != 0);
        end

        // Fetch timeout: never acknowledge.
        cnt = 0;
        @(posedge clock); #1;
        while (!bus.rom_req && cnt < 30) begin
            @(posedge clock); #1;
            cnt++;
        end
        check("timeout_fetch_seen", {31'd0, bus.rom_req}, 1);
        cnt = 0;
        while (bus.rom_req && cnt < 40) begin
            cnt++;
            @(posedge clock); #1;
        end
        check("timeout_cycles", cnt, 16);
        check("rom_err_set", {31'd0, bus.rom_err}, 1);
        cnt = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (bus.rom_req || !bus.rom_err) cnt++;
        end
        check("err_blocks_run", cnt, 0);

        // Reset clears rom_err asynchronously.
        reset = 1'b1;
        #1 check_cleared("err_rst");
        @(posedge clock); #1;
        reset  = 1'b0;
        ref_pc = 16'd0;
        #3 check("pc_reset_pulse2", {31'd0, bus.pc_reset}, 1);

        // Reset in the middle of EXEC abandons the instruction.
        cnt = 0;
        @(posedge clock); #1;
        while (!bus.rom_req && cnt < 30) begin
            @(posedge clock); #1;
            cnt++;
        end
        check("exec_rst_fetch_seen", {31'd0, bus.rom_req}, 1);
        bus.rom_ack  = 1'b1;
        bus.rom_data = 16'hE307;
        fetch_q.push_back(ref_pc);
        instr_exp_q.push_back(16'hE307);
        @(posedge clock); #1;
        bus.rom_ack = 1'b0;
        @(posedge clock); #1;
        check("mid_exec_valid", {31'd0, bus.instr_valid}, 1);
        #2 reset = 1'b1;
        #1 check_cleared("exec_rst");
        bus.run = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #3 check("pc_reset_pulse3", {31'd0, bus.pc_reset}, 1);
        repeat (4) @(posedge clock);
        #1 check("no_update_after_abort", {16'd0, hpc}, 0);
        check("scoreboard_drained", {31'd0, upd_q.size() == 0 && fetch_q.size() == 0}, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
